// File: rtl/lanes_rx_ctrl_if.sv
// Bundle of the control, status and decoder-feedback signals exchanged
// between the receive controller and its surroundings (link layer,
// configuration logic and the two-lane deserializer).
interface lanes_rx_ctrl_if;
  logic       rx_en;
  logic [1:0] gen_speed_req;
  logic       enable_dec;
  logic       sync_hdr_err;
  logic       blk_ok;
  logic       enable_deser;
  logic [1:0] gen_speed;
  logic       rx_ready;
  logic       link_err;
  logic [1:0] err_code;
  logic [7:0] restart_cnt;
  logic [2:0] state_o;

  // The controller itself
  modport slave (
    input  rx_en, gen_speed_req, enable_dec, sync_hdr_err, blk_ok,
    output enable_deser, gen_speed, rx_ready, link_err, err_code,
           restart_cnt, state_o
  );

  // Whoever drives the controller's requests and observes its status
  modport master (
    output rx_en, gen_speed_req, enable_dec, sync_hdr_err, blk_ok,
    input  enable_deser, gen_speed, rx_ready, link_err, err_code,
           restart_cnt, state_o
  );
endinterface

// File: rtl/lanes_rx_ctrl.sv
// Receive-side sequencer for the two-lane deserializer: latches the
// requested generation speed, lets it settle, enables the deserializer,
// waits for the first valid parallel word and restarts the lanes on a
// timeout, a burst of sync-header errors or a speed change.
module lanes_rx_ctrl #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int ERR_LIMIT      = 4,
  parameter int RESTART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  lanes_rx_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_WAIT_DEC = 3'd2;
  localparam logic [2:0] ST_ACTIVE   = 3'd3;
  localparam logic [2:0] ST_RESTART  = 3'd4;

  // One shared cycle counter serves the settle window, the decode timeout
  // and the restart hold, so it is sized for the longest of them.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + RESTART_CYCLES);
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESTART_LAST = CNT_W'(RESTART_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX      = ERR_W'(ERR_LIMIT);

  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_HDRERR  = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W-1:0] err_inc;
  logic [1:0]       speed_q, speed_d;
  logic             en_q, en_d;
  logic             rdy_q, rdy_d;
  logic             lerr_q, lerr_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic             req_ok;

  // A request is serviceable only while the link asks for receive and the
  // requested speed is one of the three legal encodings.
  assign req_ok = bus.rx_en && (bus.gen_speed_req != 2'b11);

  // Saturating next value of the consecutive header-error run.
  assign err_inc = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;

  // Next-state and next-output logic; outputs are derived from the next
  // state so every output leaves a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    err_d   = err_q;
    speed_d = speed_q;
    lerr_d  = 1'b0;
    code_d  = code_q;
    rcnt_d  = rcnt_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_ok) begin
          speed_d = bus.gen_speed_req;
          state_d = ST_SETTLE;
        end
      end

      ST_RESTART: begin
        if (cnt_q == RESTART_LAST) begin
          cnt_d = '0;
          if (req_ok) begin
            speed_d = bus.gen_speed_req;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_SETTLE, ST_WAIT_DEC, ST_ACTIVE: begin
        if (!req_ok) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (bus.gen_speed_req != speed_q) begin
          state_d = ST_RESTART;
          cnt_d   = '0;
        end else begin
          case (state_q)
            ST_SETTLE: begin
              if (cnt_q == SETTLE_LAST) begin
                cnt_d   = '0;
                state_d = ST_WAIT_DEC;
              end
            end
            ST_WAIT_DEC: begin
              if (bus.enable_dec) begin
                cnt_d   = '0;
                err_d   = '0;
                state_d = ST_ACTIVE;
              end else if (cnt_q == TIMEOUT_LAST) begin
                cnt_d   = '0;
                lerr_d  = 1'b1;
                code_d  = CODE_TIMEOUT;
                state_d = ST_RESTART;
              end
            end
            default: begin
              cnt_d = '0;
              if (bus.sync_hdr_err) begin
                err_d = err_inc;
                if (err_inc == ERR_MAX) begin
                  lerr_d  = 1'b1;
                  code_d  = CODE_HDRERR;
                  state_d = ST_RESTART;
                end
              end else if (bus.blk_ok) begin
                err_d = '0;
              end
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if ((state_d == ST_RESTART) && (state_q != ST_RESTART) && (rcnt_q != 8'hFF)) begin
      rcnt_d = rcnt_q + 8'd1;
    end

    en_d  = (state_d == ST_WAIT_DEC) || (state_d == ST_ACTIVE);
    rdy_d = (state_d == ST_ACTIVE);
  end

  // State and output registers; reset drops the deserializer enable at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      speed_q <= 2'b00;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      lerr_q  <= 1'b0;
      code_q  <= 2'b00;
      rcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      speed_q <= speed_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      lerr_q  <= lerr_d;
      code_q  <= code_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign bus.enable_deser = en_q;
  assign bus.gen_speed    = speed_q;
  assign bus.rx_ready     = rdy_q;
  assign bus.link_err     = lerr_q;
  assign bus.err_code     = code_q;
  assign bus.restart_cnt  = rcnt_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_lanes_rx_ctrl.sv
// Scoreboard bench for lanes_rx_ctrl: every driven cycle pushes the
// reference model's expected outputs, and a monitor on the falling edge
// pops and compares them against the DUT.
module tb_lanes_rx_ctrl;

  localparam int SETTLE_CYCLES  = 4;
  localparam int TIMEOUT_CYCLES = 512;
  localparam int ERR_LIMIT      = 4;
  localparam int RESTART_CYCLES = 2;

  localparam int P_IDLE    = 0;
  localparam int P_SETTLE  = 1;
  localparam int P_WAIT    = 2;
  localparam int P_ACTIVE  = 3;
  localparam int P_RESTART = 4;

  typedef struct packed {
    logic       en;
    logic [1:0] spd;
    logic       rdy;
    logic       lerr;
    logic [1:0] code;
    logic [7:0] rcnt;
    logic [2:0] st;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lanes_rx_ctrl_if bus ();

  lanes_rx_ctrl #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .ERR_LIMIT     (ERR_LIMIT),
    .RESTART_CYCLES(RESTART_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  obs_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase plus "cycles left" / "cycles waited" bookkeeping
  int mPhase, mSpeed, mLeft, mWaited, mErrRun, mCode, mRestarts;
  bit mLinkErr;

  function automatic void modelReset();
    mPhase = P_IDLE; mSpeed = 0; mLeft = 0; mWaited = 0;
    mErrRun = 0; mCode = 0; mRestarts = 0; mLinkErr = 0;
  endfunction

  function automatic void enterRestart();
    mPhase = P_RESTART;
    mLeft  = RESTART_CYCLES;
    if (mRestarts < 255) mRestarts++;
  endfunction

  function automatic void modelStep(bit rxEn, int req, bit dec, bit sync, bit blk);
    bit usable;
    usable   = rxEn && (req != 3);
    mLinkErr = 0;
    if (mPhase == P_IDLE) begin
      if (usable) begin
        mSpeed = req; mPhase = P_SETTLE; mLeft = SETTLE_CYCLES;
      end
    end else if (mPhase == P_RESTART) begin
      mLeft--;
      if (mLeft == 0) begin
        if (usable) begin
          mSpeed = req; mPhase = P_SETTLE; mLeft = SETTLE_CYCLES;
        end else begin
          mPhase = P_IDLE;
        end
      end
    end else if (!usable) begin
      mPhase = P_IDLE;
    end else if (req != mSpeed) begin
      enterRestart();
    end else if (mPhase == P_SETTLE) begin
      mLeft--;
      if (mLeft == 0) begin
        mPhase = P_WAIT; mWaited = 0;
      end
    end else if (mPhase == P_WAIT) begin
      mWaited++;
      if (dec) begin
        mPhase = P_ACTIVE; mErrRun = 0;
      end else if (mWaited == TIMEOUT_CYCLES) begin
        enterRestart(); mLinkErr = 1; mCode = 1;
      end
    end else begin
      if (sync) begin
        if (mErrRun < ERR_LIMIT) mErrRun++;
        if (mErrRun == ERR_LIMIT) begin
          enterRestart(); mLinkErr = 1; mCode = 2;
        end
      end else if (blk) begin
        mErrRun = 0;
      end
    end
  endfunction

  function automatic obs_t modelObs();
    obs_t o;
    o.en   = (mPhase == P_WAIT) || (mPhase == P_ACTIVE);
    o.spd  = 2'(mSpeed);
    o.rdy  = (mPhase == P_ACTIVE);
    o.lerr = mLinkErr;
    o.code = 2'(mCode);
    o.rcnt = 8'(mRestarts);
    o.st   = 3'(mPhase);
    return o;
  endfunction

  function automatic obs_t actualObs();
    obs_t o;
    o.en   = bus.enable_deser;
    o.spd  = bus.gen_speed;
    o.rdy  = bus.rx_ready;
    o.lerr = bus.link_err;
    o.code = bus.err_code;
    o.rcnt = bus.restart_cnt;
    o.st   = bus.state_o;
    return o;
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: actual en=%0b spd=%0d rdy=%0b lerr=%0b code=%0d rcnt=%0d st=%0d, required en=%0b spd=%0d rdy=%0b lerr=%0b code=%0d rcnt=%0d st=%0d",
               name, $time, act.en, act.spd, act.rdy, act.lerr, act.code, act.rcnt, act.st,
               exp.en, exp.spd, exp.rdy, exp.lerr, exp.code, exp.rcnt, exp.st);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, queue the expectation
  task automatic applyStimulus(input bit rxEn, input logic [1:0] req, input bit dec,
                               input bit sync, input bit blk);
    bus.rx_en         = rxEn;
    bus.gen_speed_req = req;
    bus.enable_dec    = dec;
    bus.sync_hdr_err  = sync;
    bus.blk_ok        = blk;
    @(posedge clk);
    modelStep(rxEn, int'(req), dec, sync, blk);
    expQ.push_back(modelObs());
    #1;
  endtask

  task automatic repeatStimulus(input int n, input bit rxEn, input logic [1:0] req, input bit dec);
    for (int i = 0; i < n; i++) applyStimulus(rxEn, req, dec, 1'b0, 1'b0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (!rst && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("cycle", actualObs(), e);
      end
    end
  end

  // Stimulus sequence
  initial begin : stimulus
    logic [1:0] rReq;
    bit         rDec;

    bus.rx_en = 1'b0; bus.gen_speed_req = 2'b00; bus.enable_dec = 1'b0;
    bus.sync_hdr_err = 1'b0; bus.blk_ok = 1'b0;
    modelReset();
    #2;
    checkOutput("reset_state", actualObs(), obs_t'(0));
    #20;
    @(negedge clk); #1 rst = 1'b0;

    $display("[TB] bring-up at GEN3, decoder valid after 133 cycles");
    repeatStimulus(133, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'($urandom_range(0, 1)));

    $display("[TB] decode timeout");
    repeatStimulus(2, 1'b0, 2'b01, 1'b0);
    repeatStimulus(1 + SETTLE_CYCLES + TIMEOUT_CYCLES + RESTART_CYCLES + 3, 1'b1, 2'b01, 1'b0);

    $display("[TB] header error runs");
    repeatStimulus(10, 1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    repeatStimulus(10, 1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
    repeatStimulus(10, 1'b1, 2'b01, 1'b1);

    $display("[TB] speed change while active");
    repeatStimulus(5, 1'b1, 2'b01, 1'b1);
    repeatStimulus(15, 1'b1, 2'b10, 1'b1);

    $display("[TB] rx_en drop in WAIT_DEC and invalid speed in IDLE");
    repeatStimulus(2, 1'b0, 2'b00, 1'b0);
    repeatStimulus(1 + SETTLE_CYCLES, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    repeatStimulus(5, 1'b1, 2'b11, 1'b0);

    $display("[TB] randomized traffic");
    rReq = 2'b00; rDec = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) rReq = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) rDec = ~rDec;
      applyStimulus($urandom_range(0, 31) != 0, rReq, rDec,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] restart counter saturation");
    for (int i = 0; i < 1000; i++) applyStimulus(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset while active");
    repeatStimulus(12, 1'b1, 2'b01, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset", actualObs(), obs_t'(0));
    expQ.delete();
    modelReset();
    @(negedge clk); #1 rst = 1'b0;
    repeatStimulus(10, 1'b1, 2'b10, 1'b1);

    @(negedge clk); #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: actual pending=%0d required=0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lanes_rx_ctrl.md
Name: lanes_rx_ctrl

Overview:
Receive-side controller that sequences the two-lane deserializer.
- Latches the requested generation speed and holds it stable for a settle window, then enables the deserializer.
- Waits for the deserializer's enable_dec (first parallel word valid) with a timeout.
- Monitors decoder sync-header errors and restarts the deserializer on timeout, error burst or speed change.
- Sits between the link/configuration logic and the lane deserializer.

Parameters:
SETTLE_CYCLES, 4, cycles gen_speed is held stable with enable_deser low before enabling.
TIMEOUT_CYCLES, 512, max cycles in WAIT_DEC for enable_dec before restart (covers 2x132-bit fill plus margin).
ERR_LIMIT, 4, consecutive sync-header errors in ACTIVE that force a restart.
RESTART_CYCLES, 2, cycles enable_deser is held low during restart.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
rx_en  input  1  receive path request from link layer (level).
gen_speed_req  input  2  requested speed: 00 GEN4, 01 GEN3, 10 GEN2, 11 invalid.
enable_dec  input  1  from deserializer; high once parallel words are valid.
sync_hdr_err  input  1  1-cycle pulse from decoder: bad sync header on a block.
blk_ok  input  1  1-cycle pulse from decoder: good block.
enable_deser  output  1  deserializer enable (registered).
gen_speed  output  2  latched speed to deserializer (registered).
rx_ready  output  1  high in ACTIVE only.
link_err  output  1  1-cycle pulse on timeout- or error-triggered restart.
err_code  output  2  cause of last link_err: 01 timeout, 10 header errors; held until next link_err or reset.
restart_cnt  output  8  count of entries to RESTART, saturates at 255.
state_o  output  3  encoded state: IDLE 0, SETTLE 1, WAIT_DEC 2, ACTIVE 3, RESTART 4.

Behaviour:
- Reset (rst=1, async): state IDLE, enable_deser 0, gen_speed 00, rx_ready 0, link_err 0, err_code 00, restart_cnt 0, all internal counters 0.
- All outputs registered. enable_deser = 1 exactly in WAIT_DEC and ACTIVE.
- IDLE:
  - If rx_en=1 and gen_speed_req!=11: latch gen_speed<=gen_speed_req, clear cycle counter, go SETTLE.
  - Otherwise stay.
- SETTLE: increment counter; when counter==SETTLE_CYCLES-1, clear counter and go WAIT_DEC. enable_deser first rises the cycle state becomes WAIT_DEC.
- WAIT_DEC:
  - Increment timer.
  - If enable_dec=1: go ACTIVE, clear err counter.
  - Else if timer==TIMEOUT_CYCLES-1: go RESTART, link_err pulse, err_code<=01.
  - enable_dec takes priority over timeout in the same cycle.
- ACTIVE:
  - sync_hdr_err increments the consecutive-error counter (saturating at ERR_LIMIT). blk_ok clears it. Both in one cycle: increment wins.
  - When the increment makes the counter ==ERR_LIMIT: go RESTART, link_err pulse, err_code<=10.
  - enable_dec falling in ACTIVE is ignored.
- RESTART:
  - enable_deser 0 for RESTART_CYCLES cycles, then re-latch gen_speed from gen_speed_req and go SETTLE.
  - If on exit rx_en=0 or gen_speed_req==11, go IDLE instead.
  - restart_cnt increments once on each entry (saturating).
- Global priority, evaluated every cycle in SETTLE/WAIT_DEC/ACTIVE, highest first:
  - (1) rx_en=0 or gen_speed_req==11: next state IDLE; no link_err, no restart_cnt change.
  - (2) gen_speed_req != latched gen_speed: go RESTART; restart_cnt increments, no link_err.
  - (3) timeout/error transitions.
- rx_en drop in RESTART: complete the RESTART hold, then IDLE.
- gen_speed output changes only on IDLE->SETTLE and RESTART exit, never while enable_deser=1.
- Reset mid-operation: immediate return to reset values; enable_deser drops asynchronously.

Test Plan:
1. Reset, rx_en=1, gen_speed_req=01 -> gen_speed=01 next cycle; enable_deser=1 after 4 SETTLE cycles; enable_dec=1 at 133 cycles -> rx_ready=1, state_o=3, link_err never pulses.
2. enable_dec held 0 -> exactly 512 cycles after WAIT_DEC entry, link_err pulse, err_code=01, enable_deser low 2 cycles, restart_cnt=1, re-enters SETTLE.
3. In ACTIVE: 3 sync_hdr_err, 1 blk_ok, then 4 sync_hdr_err -> restart only on the 4th of the final run; err_code=10. Also sync_hdr_err and blk_ok together 4 times -> restart.
4. In ACTIVE change gen_speed_req 01->10 -> RESTART without link_err, restart_cnt+1; gen_speed=10 only after enable_deser low 2 cycles.
5. rx_en dropped in WAIT_DEC, same cycle enable_dec=1 -> IDLE, enable_deser=0, rx_ready stays 0. gen_speed_req=11 in IDLE with rx_en=1 -> stays IDLE.
6. 300 forced timeouts -> restart_cnt saturates at 255. Assert rst mid-ACTIVE -> all outputs at reset values without waiting for a clock edge.
